// File: rtl/orb_packer_nch.sv
// N-channel orbital frame packer: round-robin drains fast/slow word FIFOs in fixed bursts
// into the ping-pong orbital RAM, flagging bursts that straddle a bank swap.
module orb_packer_nch #(
  parameter int unsigned NCH  = 5,
  parameter int unsigned DW   = 12,
  parameter int unsigned AW   = 11,
  parameter int unsigned UW   = 5,
  parameter int unsigned FLEN = 16,
  parameter int unsigned SLEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SW,
  input  logic [NCH*UW-1:0] usedwF,
  input  logic [NCH*DW-1:0] fData,
  input  logic [NCH*UW-1:0] usedwS,
  input  logic [NCH*DW-1:0] sData,
  input  logic [NCH*AW-1:0] sAddr,
  output logic [NCH-1:0]    rAckF,
  output logic [NCH-1:0]    rAckS,
  output logic [AW-1:0]     wAddr,
  output logic [DW-1:0]     orbWord,
  output logic              WE,
  output logic              wBank,
  output logic              busy,
  output logic [NCH-1:0]    late
);

  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_FLUSH} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  gnt_q, gnt_d;
  logic           fast_q, fast_d;
  logic [UW-1:0]  rem_q, rem_d;
  logic [UW-1:0]  rd_idx_q, rd_idx_d;
  logic [AW-1:0]  base_q, base_d;
  logic [AW-1:0]  waddr_q, waddr_d;
  logic [NCH-1:0] rack_f_q, rack_f_d;
  logic [NCH-1:0] rack_s_q, rack_s_d;
  logic [NCH-1:0] late_q, late_d;
  logic           we_q, we_d;
  logic           wbank_q, wbank_d;
  logic           busy_q, busy_d;

  logic [NCH-1:0] elig_f, elig_s;
  logic           found_f, found_s;
  logic [CW-1:0]  sel_f, sel_s, gsel;
  logic [AW-1:0]  gaddr;
  logic [NCH-1:0] gonehot;
  logic [DW-1:0]  word_mux;

  always_comb begin
    elig_f = '0;
    elig_s = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      elig_f[c] = usedwF[c*UW +: UW] >= UW'(FLEN);
      elig_s[c] = usedwS[c*UW +: UW] >= UW'(SLEN);
    end
  end

  // Round-robin scan from ptr; fast and slow winners found in the same pass.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    found_f = 1'b0;
    found_s = 1'b0;
    sel_f   = '0;
    sel_s   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!found_f && elig_f[CW'(idx)]) begin
        found_f = 1'b1;
        sel_f   = CW'(idx);
      end
      if (!found_s && elig_s[CW'(idx)]) begin
        found_s = 1'b1;
        sel_s   = CW'(idx);
      end
    end
    gsel = found_f ? sel_f : sel_s;
  end

  always_comb begin
    gaddr    = '0;
    gonehot  = '0;
    word_mux = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (gsel == CW'(c)) begin
        gaddr      = sAddr[c*AW +: AW];
        gonehot[c] = 1'b1;
      end
      if (gnt_q == CW'(c)) word_mux = fast_q ? fData[c*DW +: DW] : sData[c*DW +: DW];
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    fast_d   = fast_q;
    rem_d    = rem_q;
    rd_idx_d = rd_idx_q;
    base_d   = base_q;
    waddr_d  = waddr_q;
    rack_f_d = rack_f_q;
    rack_s_d = rack_s_q;
    late_d   = late_q;
    we_d     = 1'b0;
    wbank_d  = wbank_q;
    busy_d   = busy_q;

    // Write stage: each rdreq of the last cycle becomes a RAM write this cycle.
    if ((|rack_f_q) || (|rack_s_q)) begin
      we_d     = 1'b1;
      waddr_d  = base_q + AW'(rd_idx_q);
      rd_idx_d = rd_idx_q + 1'b1;
    end

    // wbank_q holds ~SW at burst start, so SW == wbank_q means the framer swapped.
    if (state_q != S_IDLE && SW == wbank_q) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (gnt_q == CW'(c)) late_d[c] = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found_f || found_s) begin
          gnt_d    = gsel;
          fast_d   = found_f;
          wbank_d  = ~SW;
          busy_d   = 1'b1;
          rem_d    = found_f ? UW'(FLEN - 1) : UW'(SLEN - 1);
          rd_idx_d = '0;
          base_d   = gaddr + (found_f ? AW'(0) : AW'(FLEN));
          rack_f_d = found_f ? gonehot : '0;
          rack_s_d = found_f ? '0 : gonehot;
          ptr_d    = (gsel == CW'(NCH - 1)) ? '0 : gsel + 1'b1;
          state_d  = S_BURST;
        end
      end
      S_BURST: begin
        if (rem_q == '0) begin
          rack_f_d = '0;
          rack_s_d = '0;
          state_d  = S_FLUSH;
        end else begin
          rem_d = rem_q - 1'b1;
        end
      end
      S_FLUSH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      fast_q   <= 1'b0;
      rem_q    <= '0;
      rd_idx_q <= '0;
      base_q   <= '0;
      waddr_q  <= '0;
      rack_f_q <= '0;
      rack_s_q <= '0;
      late_q   <= '0;
      we_q     <= 1'b0;
      wbank_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      fast_q   <= fast_d;
      rem_q    <= rem_d;
      rd_idx_q <= rd_idx_d;
      base_q   <= base_d;
      waddr_q  <= waddr_d;
      rack_f_q <= rack_f_d;
      rack_s_q <= rack_s_d;
      late_q   <= late_d;
      we_q     <= we_d;
      wbank_q  <= wbank_d;
      busy_q   <= busy_d;
    end
  end

  // FIFO q only becomes valid in the write cycle, so the data path is a gated mux.
  assign orbWord = we_q ? word_mux : '0;
  assign rAckF   = rack_f_q;
  assign rAckS   = rack_s_q;
  assign wAddr   = waddr_q;
  assign WE      = we_q;
  assign wBank   = wbank_q;
  assign busy    = busy_q;
  assign late    = late_q;

endmodule

// File: tb/tb_orb_packer_nch.sv
// Directed bench for orb_packer_nch with behavioural non-show-ahead FIFOs per channel.
module tb_orb_packer_nch;

  localparam int unsigned NCH = 5, DW = 12, AW = 11, UW = 5, FLEN = 16, SLEN = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic SW  = 1'b0;
  logic [NCH*UW-1:0] usedwF, usedwS;
  logic [NCH*DW-1:0] fData, sData;
  logic [NCH*AW-1:0] sAddr;
  logic [NCH-1:0]    rAckF, rAckS, late;
  logic [AW-1:0]     wAddr;
  logic [DW-1:0]     orbWord;
  logic              WE, wBank, busy;

  int fill_f[NCH] = '{default: 0};
  int fill_s[NCH] = '{default: 0};
  int pop_f[NCH]  = '{default: 0};
  int pop_s[NCH]  = '{default: 0};
  logic [AW-1:0] sa[NCH] = '{default: '0};
  logic [DW-1:0] fq[NCH] = '{default: '0};
  logic [DW-1:0] sq[NCH] = '{default: '0};

  int total = 0;
  int bad   = 0;

  logic [NCH-1:0] c_rf[0:99], c_rs[0:99], c_late[0:99];
  logic           c_we[0:99], c_bank[0:99], c_busy[0:99];
  logic [AW-1:0]  c_addr[0:99];
  logic [DW-1:0]  c_word[0:99];

  orb_packer_nch #(.NCH(NCH), .DW(DW), .AW(AW), .UW(UW), .FLEN(FLEN), .SLEN(SLEN)) dut (
    .clk(clk), .rst(rst), .SW(SW),
    .usedwF(usedwF), .fData(fData), .usedwS(usedwS), .sData(sData), .sAddr(sAddr),
    .rAckF(rAckF), .rAckS(rAckS), .wAddr(wAddr), .orbWord(orbWord),
    .WE(WE), .wBank(wBank), .busy(busy), .late(late)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fword(input int c, input int k);
    return DW'(c * 256 + k);
  endfunction

  function automatic logic [DW-1:0] sword(input int c, input int k);
    return DW'(2048 + c * 256 + k);
  endfunction

  // FIFO model: q updates one edge after rdreq.
  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rAckF[c]) begin
        fq[c]    <= fword(c, pop_f[c]);
        pop_f[c] <= pop_f[c] + 1;
      end
      if (rAckS[c]) begin
        sq[c]    <= sword(c, pop_s[c]);
        pop_s[c] <= pop_s[c] + 1;
      end
    end
  end

  always_comb begin
    usedwF = '0;
    usedwS = '0;
    fData  = '0;
    sData  = '0;
    sAddr  = '0;
    for (int c = 0; c < NCH; c++) begin
      usedwF[c*UW +: UW] = UW'(fill_f[c] - pop_f[c]);
      usedwS[c*UW +: UW] = UW'(fill_s[c] - pop_s[c]);
      fData[c*DW +: DW]  = fq[c];
      sData[c*DW +: DW]  = sq[c];
      sAddr[c*AW +: AW]  = sa[c];
    end
  end

  task automatic capture(input int n, input int tog_j);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      c_rf[j] = rAckF;  c_rs[j] = rAckS;  c_late[j] = late;
      c_we[j] = WE;     c_bank[j] = wBank; c_busy[j] = busy;
      c_addr[j] = wAddr; c_word[j] = orbWord;
      if (j == tog_j) SW = ~SW;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rAckF !== '0)   begin bad++; $display("FAIL reset_rAckF got=%b exp=0", rAckF); end
    total++; if (rAckS !== '0)   begin bad++; $display("FAIL reset_rAckS got=%b exp=0", rAckS); end
    total++; if (WE !== 1'b0)    begin bad++; $display("FAIL reset_WE got=%b exp=0", WE); end
    total++; if (wAddr !== '0)   begin bad++; $display("FAIL reset_wAddr got=%0d exp=0", wAddr); end
    total++; if (orbWord !== '0) begin bad++; $display("FAIL reset_orbWord got=%h exp=0", orbWord); end
    total++; if (wBank !== 1'b0) begin bad++; $display("FAIL reset_wBank got=%b exp=0", wBank); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (late !== '0)    begin bad++; $display("FAIL reset_late got=%b exp=0", late); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL idle_empty_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_fast;
    logic [NCH-1:0] exp_rf;
    logic exp_we, exp_busy;
    sa[2] = AW'(100);
    fill_f[2] += 16;
    capture(20, -1);
    for (int j = 0; j < 20; j++) begin
      exp_rf   = (j < 16) ? NCH'(5'b00100) : '0;
      exp_we   = (j >= 1 && j <= 16);
      exp_busy = (j <= 16);
      total++; if (c_rf[j] !== exp_rf) begin bad++; $display("FAIL single_rAckF j=%0d got=%b exp=%b", j, c_rf[j], exp_rf); end
      total++; if (c_rs[j] !== '0) begin bad++; $display("FAIL single_rAckS j=%0d got=%b exp=0", j, c_rs[j]); end
      total++; if (c_we[j] !== exp_we) begin bad++; $display("FAIL single_WE j=%0d got=%b exp=%b", j, c_we[j], exp_we); end
      total++; if (c_busy[j] !== exp_busy) begin bad++; $display("FAIL single_busy j=%0d got=%b exp=%b", j, c_busy[j], exp_busy); end
      if (exp_we) begin
        total++; if (c_addr[j] !== AW'(100 + j - 1)) begin bad++; $display("FAIL single_addr j=%0d got=%0d exp=%0d", j, c_addr[j], 100 + j - 1); end
        total++; if (c_word[j] !== fword(2, j - 1)) begin bad++; $display("FAIL single_word j=%0d got=%h exp=%h", j, c_word[j], fword(2, j - 1)); end
        total++; if (c_bank[j] !== 1'b1) begin bad++; $display("FAIL single_wBank j=%0d got=%b exp=1", j, c_bank[j]); end
      end
    end
    total++; if (c_late[19] !== '0) begin bad++; $display("FAIL single_late got=%b exp=0", c_late[19]); end
  endtask

  task automatic test_round_robin;
    int base[NCH];
    int j0;
    base = '{0, 0, 16, 0, 0};
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      sa[c] = AW'(c * 300);
      fill_f[c] += 16;
    end
    capture(92, -1);
    for (int b = 0; b < NCH; b++) begin
      j0 = 18 * b;
      total++; if (c_rf[j0] !== NCH'(1 << b)) begin bad++; $display("FAIL rr_grant b=%0d got=%b exp=%b", b, c_rf[j0], NCH'(1 << b)); end
      total++; if (c_rf[j0+15] !== NCH'(1 << b)) begin bad++; $display("FAIL rr_last_ack b=%0d got=%b exp=%b", b, c_rf[j0+15], NCH'(1 << b)); end
      total++; if (c_rf[j0+16] !== '0) begin bad++; $display("FAIL rr_ack_end b=%0d got=%b exp=0", b, c_rf[j0+16]); end
      total++; if (c_we[j0+16] !== 1'b1) begin bad++; $display("FAIL rr_flush_we b=%0d got=%b exp=1", b, c_we[j0+16]); end
      total++; if (c_busy[j0+17] !== 1'b0) begin bad++; $display("FAIL rr_idle b=%0d got=%b exp=0", b, c_busy[j0+17]); end
      total++; if (c_addr[j0+1] !== AW'(b * 300)) begin bad++; $display("FAIL rr_addr b=%0d got=%0d exp=%0d", b, c_addr[j0+1], b * 300); end
      total++; if (c_word[j0+1] !== fword(b, base[b])) begin bad++; $display("FAIL rr_word0 b=%0d got=%h exp=%h", b, c_word[j0+1], fword(b, base[b])); end
      total++; if (c_word[j0+16] !== fword(b, base[b] + 15)) begin bad++; $display("FAIL rr_word15 b=%0d got=%h exp=%h", b, c_word[j0+16], fword(b, base[b] + 15)); end
    end
  endtask

  task automatic test_fast_priority;
    sa[0] = AW'(200);
    fill_s[0] += 4;
    fill_f[3] += 16;
    capture(26, -1);
    total++; if (c_rf[0] !== NCH'(5'b01000)) begin bad++; $display("FAIL prio_fast_first got=%b exp=01000", c_rf[0]); end
    total++; if (c_rs[0] !== '0) begin bad++; $display("FAIL prio_no_slow_first got=%b exp=0", c_rs[0]); end
    total++; if (c_word[1] !== fword(3, 16)) begin bad++; $display("FAIL prio_fast_word got=%h exp=%h", c_word[1], fword(3, 16)); end
    total++; if (c_rs[18] !== NCH'(5'b00001)) begin bad++; $display("FAIL prio_slow_grant got=%b exp=00001", c_rs[18]); end
    total++; if (c_rs[21] !== NCH'(5'b00001)) begin bad++; $display("FAIL prio_slow_last got=%b exp=00001", c_rs[21]); end
    total++; if (c_rs[22] !== '0) begin bad++; $display("FAIL prio_slow_end got=%b exp=0", c_rs[22]); end
    for (int k = 0; k < 4; k++) begin
      total++; if (c_addr[19+k] !== AW'(216 + k)) begin bad++; $display("FAIL prio_slow_addr k=%0d got=%0d exp=%0d", k, c_addr[19+k], 216 + k); end
      total++; if (c_word[19+k] !== sword(0, k)) begin bad++; $display("FAIL prio_slow_word k=%0d got=%h exp=%h", k, c_word[19+k], sword(0, k)); end
    end
    total++; if (c_we[23] !== 1'b0) begin bad++; $display("FAIL prio_we_idle got=%b exp=0", c_we[23]); end
    for (int j = 0; j < 26; j++) begin
      total++; if ((c_rf[j] != '0) && (c_rs[j] != '0)) begin bad++; $display("FAIL prio_ack_excl j=%0d got=%b/%b exp=one_zero", j, c_rf[j], c_rs[j]); end
    end
  endtask

  task automatic test_late_swap;
    sa[1] = AW'(300);
    fill_f[1] += 16;
    capture(20, 4);
    for (int k = 0; k < 16; k++) begin
      total++; if (c_bank[1+k] !== 1'b1) begin bad++; $display("FAIL late_bank k=%0d got=%b exp=1", k, c_bank[1+k]); end
      total++; if (c_addr[1+k] !== AW'(300 + k)) begin bad++; $display("FAIL late_addr k=%0d got=%0d exp=%0d", k, c_addr[1+k], 300 + k); end
    end
    total++; if (c_word[1] !== fword(1, 16)) begin bad++; $display("FAIL late_word got=%h exp=%h", c_word[1], fword(1, 16)); end
    total++; if (c_late[4] !== '0) begin bad++; $display("FAIL late_before got=%b exp=0", c_late[4]); end
    total++; if (c_late[5] !== NCH'(5'b00010)) begin bad++; $display("FAIL late_set got=%b exp=00010", c_late[5]); end
    total++; if (c_late[19] !== NCH'(5'b00010)) begin bad++; $display("FAIL late_end got=%b exp=00010", c_late[19]); end
    repeat (5) @(negedge clk);
    total++; if (late !== NCH'(5'b00010)) begin bad++; $display("FAIL late_sticky got=%b exp=00010", late); end
  endtask

  task automatic test_wrap;
    sa[4] = AW'(2040);
    fill_f[4] += 16;
    SW = 1'b0;
    capture(20, -1);
    total++; if (c_rf[0] !== NCH'(5'b10000)) begin bad++; $display("FAIL wrap_grant got=%b exp=10000", c_rf[0]); end
    total++; if (c_bank[1] !== 1'b1) begin bad++; $display("FAIL wrap_swap_bank got=%b exp=1", c_bank[1]); end
    total++; if (c_addr[1] !== AW'(2040)) begin bad++; $display("FAIL wrap_addr0 got=%0d exp=2040", c_addr[1]); end
    total++; if (c_addr[8] !== AW'(2047)) begin bad++; $display("FAIL wrap_addr7 got=%0d exp=2047", c_addr[8]); end
    total++; if (c_addr[9] !== AW'(0)) begin bad++; $display("FAIL wrap_addr8 got=%0d exp=0", c_addr[9]); end
    total++; if (c_addr[16] !== AW'(7)) begin bad++; $display("FAIL wrap_addr15 got=%0d exp=7", c_addr[16]); end
    total++; if (c_word[16] !== fword(4, 31)) begin bad++; $display("FAIL wrap_word got=%h exp=%h", c_word[16], fword(4, 31)); end
    total++; if (c_late[19] !== NCH'(5'b00010)) begin bad++; $display("FAIL wrap_late got=%b exp=00010", c_late[19]); end
  endtask

  task automatic test_mid_reset;
    fill_f[3] += 16;
    capture(8, -1);
    total++; if (c_rf[7] !== NCH'(5'b01000)) begin bad++; $display("FAIL mr_in_burst got=%b exp=01000", c_rf[7]); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (rAckF !== '0)   begin bad++; $display("FAIL mr_rAckF got=%b exp=0", rAckF); end
    total++; if (WE !== 1'b0)    begin bad++; $display("FAIL mr_WE got=%b exp=0", WE); end
    total++; if (wAddr !== '0)   begin bad++; $display("FAIL mr_wAddr got=%0d exp=0", wAddr); end
    total++; if (orbWord !== '0) begin bad++; $display("FAIL mr_orbWord got=%h exp=0", orbWord); end
    total++; if (wBank !== 1'b0) begin bad++; $display("FAIL mr_wBank got=%b exp=0", wBank); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL mr_busy got=%b exp=0", busy); end
    total++; if (late !== '0)    begin bad++; $display("FAIL mr_late got=%b exp=0", late); end
    @(negedge clk);
    fill_f[3] += 16 - (fill_f[3] - pop_f[3]);
    fill_f[0] += 16;
    rst = 1'b1;
    capture(38, -1);
    total++; if (c_rf[0] !== NCH'(5'b00001)) begin bad++; $display("FAIL mr_first_grant got=%b exp=00001", c_rf[0]); end
    total++; if (c_addr[1] !== AW'(200)) begin bad++; $display("FAIL mr_ch0_addr got=%0d exp=200", c_addr[1]); end
    total++; if (c_word[1] !== fword(0, 16)) begin bad++; $display("FAIL mr_ch0_word got=%h exp=%h", c_word[1], fword(0, 16)); end
    total++; if (c_rf[18] !== NCH'(5'b01000)) begin bad++; $display("FAIL mr_second_grant got=%b exp=01000", c_rf[18]); end
    total++; if (c_word[19] !== fword(3, 40)) begin bad++; $display("FAIL mr_ch3_word got=%h exp=%h", c_word[19], fword(3, 40)); end
    total++; if (c_busy[36] !== 1'b0) begin bad++; $display("FAIL mr_final_idle got=%b exp=0", c_busy[36]); end
  endtask

  initial begin
    test_reset();
    test_single_fast();
    test_round_robin();
    test_fast_priority();
    test_late_swap();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/orb_packer_nch.md
# orb_packer_nch

N-channel orbital frame packer: drains per-channel fast and slow 12-bit word FIFOs in fixed-length bursts into the double-buffered orbital RAM. It generalises the two-channel packer to `NCH` channels, with parametrised burst lengths, round-robin fairness and per-channel late-swap flags. It sits between the `writer`/FIFO pairs of each UART channel and the `ramM16` ping-pong banks. `SW` comes from the M16 framer.

## Interface

Parameters:
- `NCH`, 5, number of UART channels
- `DW`, 12, orbital word width
- `AW`, 11, RAM address width
- `UW`, 5, FIFO `usedw` width
- `FLEN`, 16, words per fast burst (1..2^UW-1)
- `SLEN`, 4, words per slow burst (1..2^UW-1)

Ports:
- `clk`  in  1  system clock (80 MHz domain)
- `rst`  in  1  reset, synchronous, active-low
- `SW`  in  1  bank currently read by the framer
- `usedwF`  in  NCH*UW  fast FIFO fill levels, channel c at [c*UW +: UW]
- `fData`  in  NCH*DW  fast FIFO q outputs
- `usedwS`  in  NCH*UW  slow FIFO fill levels
- `sData`  in  NCH*DW  slow FIFO q outputs
- `sAddr`  in  NCH*AW  per-channel base address in the frame
- `rAckF`  out  NCH  fast FIFO rdreq, one-hot or zero
- `rAckS`  out  NCH  slow FIFO rdreq, one-hot or zero
- `wAddr`  out  AW  RAM write address
- `orbWord`  out  DW  RAM write data
- `WE`  out  1  RAM write enable
- `wBank`  out  1  target bank for the current write; equals ~SW latched at burst start
- `busy`  out  1  burst in progress
- `late`  out  NCH  sticky: a burst of channel c spanned an SW change

## Operation

- FIFOs are non-show-ahead: q is valid one cycle after rdreq.
- A channel is fast-eligible when `usedwF[c] >= FLEN` and slow-eligible when `usedwS[c] >= SLEN`.
- State machine `IDLE -> BURST -> FLUSH -> IDLE`.
- **IDLE**:
  - Scan channels starting at `ptr`, wrapping modulo NCH.
  - The first fast-eligible channel wins.
  - If no channel is fast-eligible, the same scan selects the first slow-eligible channel.
  - On a grant: latch channel `g`, kind (fast/slow), `L` (FLEN or SLEN) and `wBank <= ~SW`; set `ptr <= (g+1) mod NCH`; go to BURST.
  - With no eligible channel, stay in IDLE.
- **BURST**: assert the granted rAck for exactly L cycles, then go to FLUSH.
- **Data pipeline**:
  - Each word read is presented one cycle after its rAck: `WE=1`, `orbWord` = FIFO q.
  - Fast word k: `wAddr = sAddr[g] + k`.
  - Slow word k: `wAddr = sAddr[g] + FLEN + k`.
  - Address sums wrap modulo 2^AW.
- **FLUSH**: the final write occurs; go to IDLE.
- **Late detection**: if SW differs from its burst-start value at any cycle of BURST or FLUSH, set `late[g]`. The burst still completes into the latched `wBank`.
- `late` clears only on reset.
- Fast priority is global: slow bursts run only when no channel is fast-eligible.

## Timing

- Grant in IDLE at cycle t:
  - rAck high at t+1 .. t+L.
  - WE high at t+2 .. t+L+1.
  - Next IDLE at t+L+2.
  - Next earliest rAck at t+L+3.
- Burst cost is L+2 cycles. `busy` is high from t+1 through t+L+1.
- `usedw` is sampled only in IDLE. The counts decremented by the burst just drained are visible by the next IDLE because of FIFO latency.
- `rAckF` and `rAckS` are never both non-zero.
- WE is never high in IDLE.
- **Reset** (rst=0 at a clock edge):
  - All outputs go to 0: `rAck*`, `WE`, `wAddr`, `orbWord`, `wBank`, `busy`, `late`.
  - `ptr` goes to 0 and the state goes to IDLE.
  - A burst in progress is abandoned. The FIFO words already acked are lost; this is required behaviour.
- First grant is possible at the first edge after rst returns to 1.
- If SW toggles in the same cycle as a grant, `wBank` takes the new ~SW and `late` is not set.

## Test plan

- **Single fast burst.** NCH=5, FLEN=16; `usedwF[2]=16`, `sAddr[2]=100`, SW=0; all other FIFOs empty.
  - `rAckF[2]` high for 16 cycles.
  - WE for 16 cycles at addresses 100..115 with FIFO data in order.
  - `wBank=1`, `late=0`.
- **Round-robin.** All five fast FIFOs hold 16 words; ptr=0 after reset.
  - Grants in order 0,1,2,3,4.
  - Each burst is 18 cycles.
- **Fast priority.** `usedwS[0]=4` and `usedwF[3]=16`.
  - The fast burst of channel 3 goes first.
  - Then slow channel 0 writes 4 words at `sAddr[0]+16 .. +19`.
- **Late swap.** SW toggles at cycle 5 of a channel-1 fast burst.
  - All 16 writes stay in the latched bank.
  - `late[1]=1` and stays set; other `late` bits stay 0.
- **Wrap.** `sAddr[4]=2040`, FLEN=16.
  - Writes land at 2040..2047 then 0..7.
- **Mid-burst reset.** rst=0 at burst cycle 8.
  - Next cycle: all outputs 0, no WE.
  - After release, with a FIFO re-filled to 16, a grant to channel 0 first.
